vec_stream_ctrl: RTL and testbench



---
 rtl/vec_stream_pkg.sv | 15 +
 rtl/vec_stream_delay.sv | 50 +++++
 rtl/vec_stream_ctrl.sv | 118 +++++++++++
 tb/tb_vec_stream_ctrl.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/vec_stream_pkg.sv
// Shared types and defaults for the vector-add stream sequencer.
package vec_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  localparam int unsigned ADDR_W_DEF = 10;
  localparam int unsigned RD_LAT_DEF = 2;
  localparam int unsigned RD_LAT_MAX = 8;

endpackage

// File: rtl/vec_stream_delay.sv
// Read-to-write delay line: DEPTH-deep shift register of {valid, addr}.
// The tail drives the result BRAM strobes; o_empty reports that nothing is
// queued behind the tail, i.e. the line is empty once the current edge passes.
module vec_stream_delay
  import vec_stream_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned DEPTH  = RD_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_valid,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              o_valid,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_empty
);

  logic [DEPTH-1:0]  r_valid;
  logic [ADDR_W-1:0] r_addr [DEPTH];
  logic              w_empty;

  // Shift {valid, addr} one stage per cycle; invalid entries carry a zero address.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= '0;
      for (int unsigned k = 0; k < DEPTH; k++) r_addr[k] <= '0;
    end else begin
      r_valid[0] <= i_valid;
      r_addr[0]  <= i_valid ? i_addr : '0;
      for (int unsigned k = 1; k < DEPTH; k++) begin
        r_valid[k] <= r_valid[k-1];
        r_addr[k]  <= r_addr[k-1];
      end
    end
  end

  // Empty when no stage ahead of the tail holds a valid entry.
  always_comb begin
    w_empty = 1'b1;
    for (int unsigned k = 0; k + 1 < DEPTH; k++) begin
      if (r_valid[k]) w_empty = 1'b0;
    end
  end

  assign o_valid = r_valid[DEPTH-1];
  assign o_addr  = r_addr[DEPTH-1];
  assign o_empty = w_empty;

endmodule

// File: rtl/vec_stream_ctrl.sv
// Vector-add stream sequencer: streams operand reads 0..L-1 after a start
// pulse, then issues result writes RD_LAT cycles behind each read.
// Optional feature macro: VEC_STREAM_CTRL_ABORT_EN (adds the abort input).
module vec_stream_ctrl
  import vec_stream_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned RD_LAT = RD_LAT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
`ifdef VEC_STREAM_CTRL_ABORT_EN
  input  logic              abort,
`endif
  input  logic [ADDR_W:0]   len,
  output logic              enr,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              enw,
  output logic              wea,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   i
);

  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

  state_t            r_state;
  state_t            w_state_nxt;
  logic [ADDR_W:0]   r_len;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [ADDR_W:0]   r_wr_cnt;
  logic [ADDR_W:0]   w_len_clamped;
  logic              w_accept;
  logic              w_last_rd;
  logic              w_abort;
  logic              w_stop;
  logic              w_run;
  logic              w_tail_valid;
  logic [ADDR_W-1:0] w_tail_addr;
  logic              w_drain_empty;

  assign w_len_clamped = (len > MAX_LEN) ? MAX_LEN : len;
  assign w_accept      = (r_state == ST_IDLE) && start;
  assign w_run         = (r_state == ST_RUN);
  // Compare against L-1 on the widened address so L = 2^ADDR_W never wraps.
  assign w_last_rd     = ({1'b0, r_rd_addr} == (r_len - (ADDR_W+1)'(1)));

`ifdef VEC_STREAM_CTRL_ABORT_EN
  assign w_abort = abort;
`else
  assign w_abort = 1'b0;
`endif

  assign w_stop = w_last_rd || w_abort;

  // Next-state decode for the IDLE -> RUN -> DRAIN -> FIN sequence.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_state_nxt = (len == '0) ? ST_FIN : ST_RUN;
      ST_RUN:   if (w_stop) w_state_nxt = ST_DRAIN;
      ST_DRAIN: if (w_drain_empty) w_state_nxt = ST_FIN;
      ST_FIN:   w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Latch the clamped length only when a start is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        r_len <= '0;
    else if (w_accept) r_len <= w_len_clamped;
  end

  // Read address: restarts at 0 on accept, advances each RUN cycle until the last read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                r_rd_addr <= '0;
    else if (w_accept)         r_rd_addr <= '0;
    else if (w_run && !w_stop) r_rd_addr <= r_rd_addr + ADDR_W'(1);
  end

  // Write counter: cleared on accept, bumped on every issued write, held otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            r_wr_cnt <= '0;
    else if (w_accept)     r_wr_cnt <= '0;
    else if (w_tail_valid) r_wr_cnt <= r_wr_cnt + (ADDR_W+1)'(1);
  end

  vec_stream_delay #(
    .ADDR_W (ADDR_W),
    .DEPTH  (RD_LAT)
  ) u_delay (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_valid (w_run),
    .i_addr  (r_rd_addr),
    .o_valid (w_tail_valid),
    .o_addr  (w_tail_addr),
    .o_empty (w_drain_empty)
  );

  assign enr     = w_run;
  assign rd_addr = r_rd_addr;
  assign enw     = w_tail_valid;
  assign wea     = w_tail_valid;
  assign wr_addr = w_tail_addr;
  assign busy    = (r_state == ST_RUN) || (r_state == ST_DRAIN);
  assign done    = (r_state == ST_FIN);
  assign i       = r_wr_cnt;

endmodule

// File: tb/tb_vec_stream_ctrl.sv
// Self-checking bench for vec_stream_ctrl (ADDR_W=10, RD_LAT=2).
// Expected waveforms come from a per-cycle timing model relative to the
// accepting edge: reads in 1..L, writes in RD_LAT+1..L+RD_LAT, done after.
module tb_vec_stream_ctrl;

  localparam int unsigned AW   = 10;
  localparam int unsigned LAT  = 2;
  localparam int unsigned MAXL = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [AW:0]   len_drv;
  logic          enr;
  logic [AW-1:0] rd_addr;
  logic          enw;
  logic          wea;
  logic [AW-1:0] wr_addr;
  logic          busy;
  logic          done;
  logic [AW:0]   i_cnt;
`ifdef VEC_STREAM_CTRL_ABORT_EN
  logic          abort;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  vec_stream_ctrl #(
    .ADDR_W (AW),
    .RD_LAT (LAT)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
`ifdef VEC_STREAM_CTRL_ABORT_EN
    .abort   (abort),
`endif
    .len     (len_drv),
    .enr     (enr),
    .rd_addr (rd_addr),
    .enw     (enw),
    .wea     (wea),
    .wr_addr (wr_addr),
    .busy    (busy),
    .done    (done),
    .i       (i_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Compare every output against the model for cycle t of a run of L elements.
  task automatic check_cycle(input int t, input int L);
    int  d;
    int  wr_done;
    bit  e_rd;
    bit  e_wr;
    e_rd    = (t >= 1) && (t <= L);
    e_wr    = (t >= LAT + 1) && (t <= L + LAT);
    d       = (L == 0) ? 1 : L + LAT + 1;
    wr_done = ((t - 1 < L + LAT) ? t - 1 : L + LAT) - LAT;
    if (wr_done < 0) wr_done = 0;
    chk("enr", 32'(enr), 32'(e_rd));
    if (e_rd) chk("rd_addr", 32'(rd_addr), 32'(t - 1));
    chk("enw", 32'(enw), 32'(e_wr));
    chk("wea", 32'(wea), 32'(e_wr));
    if (e_wr) chk("wr_addr", 32'(wr_addr), 32'(t - 1 - LAT));
    chk("busy", 32'(busy), 32'((L > 0) && (t >= 1) && (t <= L + LAT)));
    chk("done", 32'(done), 32'(t == d));
    chk("i", 32'(i_cnt), 32'(wr_done));
  endtask

  task automatic check_idle(input int exp_i);
    chk("idle_enr", 32'(enr), 32'(0));
    chk("idle_enw", 32'(enw), 32'(0));
    chk("idle_busy", 32'(busy), 32'(0));
    chk("idle_done", 32'(done), 32'(0));
    chk("idle_i", 32'(i_cnt), 32'(exp_i));
  endtask

  // Caller is at a negedge in an IDLE cycle. Issues start, checks the whole
  // run, optionally spraying ignored starts, and returns at the negedge of
  // the IDLE cycle right after done.
  task automatic run(input int len_in, input bit noise, input int abort_at);
    int L;
    int last;
    L = (len_in > int'(MAXL)) ? int'(MAXL) : len_in;
`ifdef VEC_STREAM_CTRL_ABORT_EN
    if (abort_at > 0 && abort_at < L) L = abort_at;
`endif
    start   = 1'b1;
    len_drv = (AW+1)'(len_in);
    @(negedge clk);
    start = 1'b0;
    last  = (L == 0) ? 1 : L + LAT + 1;
    for (int t = 1; t <= last; t++) begin
      check_cycle(t, L);
`ifdef VEC_STREAM_CTRL_ABORT_EN
      abort = (t == abort_at);
`endif
      if (noise && $urandom_range(0, 2) == 0) begin
        start   = 1'b1;
        len_drv = (AW+1)'($urandom_range(0, 15));
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    start = 1'b0;
`ifdef VEC_STREAM_CTRL_ABORT_EN
    abort = 1'b0;
`endif
    check_idle(L);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    start   = 1'b0;
    len_drv = '0;
`ifdef VEC_STREAM_CTRL_ABORT_EN
    abort   = 1'b0;
`endif
    // Reset state and a quiet idle period.
    repeat (3) @(negedge clk);
    chk("rst_enr", 32'(enr), 32'(0));
    chk("rst_rd_addr", 32'(rd_addr), 32'(0));
    chk("rst_wr_addr", 32'(wr_addr), 32'(0));
    check_idle(0);
    rst_n = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      check_idle(0);
    end

    // Directed: len=4, then len=0 followed back-to-back by a full-length run.
    run(4, 1'b0, 0);
    run(0, 1'b0, 0);
    run(1024, 1'b0, 0);
    // Oversized length clamps to 2^ADDR_W.
    run(2047, 1'b0, 0);

    // len=8 run with stray starts, including len=3, all ignored.
    start   = 1'b1;
    len_drv = (AW+1)'(8);
    @(negedge clk);
    start = 1'b0;
    check_cycle(1, 8);
    start   = 1'b1;
    len_drv = (AW+1)'(3);
    @(negedge clk);
    start = 1'b0;
    for (int t = 2; t <= 8 + LAT + 1; t++) begin
      check_cycle(t, 8);
      start   = (t % 3 == 0);
      len_drv = (AW+1)'(3);
      @(negedge clk);
    end
    start = 1'b0;
    check_idle(8);
    // Start in the cycle after done is accepted.
    run(5, 1'b1, 0);

    // Asynchronous reset in cycle 3 of a len=8 run.
    start   = 1'b1;
    len_drv = (AW+1)'(8);
    @(negedge clk);
    start = 1'b0;
    for (int t = 1; t <= 3; t++) begin
      check_cycle(t, 8);
      if (t < 3) @(negedge clk);
    end
    rst_n = 1'b0;
    #1;
    chk("arst_enr", 32'(enr), 32'(0));
    chk("arst_enw", 32'(enw), 32'(0));
    chk("arst_wea", 32'(wea), 32'(0));
    chk("arst_busy", 32'(busy), 32'(0));
    chk("arst_i", 32'(i_cnt), 32'(0));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      check_idle(0);
    end
    run(8, 1'b0, 0);

`ifdef VEC_STREAM_CTRL_ABORT_EN
    // Abort in cycle 4 of a len=10 run leaves four elements.
    run(10, 1'b0, 4);
    // Abort while idle has no effect.
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check_idle(4);
    run(6, 1'b0, 0);
`endif

    // Randomized runs with stray starts.
    for (int r = 0; r < 8; r++) begin
      run(int'($urandom_range(1, 40)), 1'b1, 0);
    end
    run(1, 1'b1, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
